// File: rtl/snax_hwpe_periph_pkg.sv
// Shared definitions for the HWPE peripheral bus responder: fixed addresses,
// the job state encoding and the request/response bundles used by the initiator.
package snax_hwpe_periph_pkg;

  localparam logic [31:0] TriggerAddr    = 32'h0000_0000;
  localparam logic [31:0] StatusAddr     = 32'h0000_0004;
  localparam logic [31:0] SoftClearAddr  = 32'h0000_0008;
  localparam logic [31:0] DefaultRegBase = 32'h0000_0040;
  localparam int          DefaultIdWidth = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } job_state_e;

  typedef struct packed {
    logic [DefaultIdWidth-1:0] id;
    logic [31:0]               add;
    logic                      wen;
    logic [3:0]                be;
    logic [31:0]               data;
  } periph_req_t;

  typedef struct packed {
    logic [DefaultIdWidth-1:0] r_id;
    logic                      r_valid;
    logic [31:0]               r_data;
  } periph_rsp_t;

endpackage

// File: rtl/snax_hwpe_periph_regfile.sv
// Periph bus responder: generic config register bank plus a trigger/status/clear
// job interface that starts the HWPE engine and counts completed jobs.
module snax_hwpe_periph_regfile
  import snax_hwpe_periph_pkg::*;
#(
  parameter int          NumRegs = 16,
  parameter int          IdWidth = 5,
  parameter logic [31:0] RegBase = DefaultRegBase
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    periph_req_i,
  output logic                    periph_gnt_o,
  input  logic [31:0]             periph_add_i,
  input  logic                    periph_wen_i,
  input  logic [3:0]              periph_be_i,
  input  logic [31:0]             periph_data_i,
  input  logic [IdWidth-1:0]      periph_id_i,
  output logic [31:0]             periph_r_data_o,
  output logic                    periph_r_valid_o,
  output logic [IdWidth-1:0]      periph_r_id_o,
  output logic [NumRegs*32-1:0]   cfg_regs_o,
  output logic                    start_o,
  input  logic                    done_i,
  output logic                    busy_o
);

  localparam int IdxWidth = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic                r_valid_q;
  logic [31:0]         r_data_q;
  logic [IdWidth-1:0]  r_id_q;
  logic [31:0]         cfg_q [NumRegs];
  job_state_e          state_q, state_d;
  logic [7:0]          job_count_q, job_count_d;
  logic                start_q, start_d;

  logic                accept, wr_en, rd_en;
  logic                is_trigger, is_status, is_clear, cfg_hit;
  logic [31:0]         cfg_offset;
  logic [IdxWidth-1:0] cfg_idx;
  logic                trigger_wr, clear_wr, cfg_wr;
  logic [31:0]         rd_data;

  // Holding off the grant while a response is out keeps the initiator's
  // still-asserted req from being accepted a second time.
  assign periph_gnt_o = periph_req_i & ~r_valid_q;
  assign accept       = periph_req_i & periph_gnt_o;
  assign wr_en        = accept & ~periph_wen_i;
  assign rd_en        = accept & periph_wen_i;

  assign is_trigger = (periph_add_i == TriggerAddr);
  assign is_status  = (periph_add_i == StatusAddr);
  assign is_clear   = (periph_add_i == SoftClearAddr);
  assign cfg_offset = periph_add_i - RegBase;
  assign cfg_hit    = (periph_add_i >= RegBase) &&
                      (cfg_offset < 32'(NumRegs * 4)) &&
                      (periph_add_i[1:0] == 2'b00);
  assign cfg_idx    = cfg_offset[IdxWidth+1:2];

  assign trigger_wr = wr_en & is_trigger;
  assign clear_wr   = wr_en & is_clear;
  assign cfg_wr     = wr_en & cfg_hit;

  always_comb begin
    rd_data = '0;
    if (is_status) begin
      rd_data = {16'h0000, job_count_q, 7'h00, (state_q == RUNNING)};
    end else if (cfg_hit) begin
      rd_data = cfg_q[cfg_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
    end else begin
      r_valid_q <= rd_en;
      if (rd_en) begin
        r_data_q <= rd_data;
        r_id_q   <= periph_id_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_wr) begin
      for (int k = 0; k < NumRegs; k++) cfg_q[k] <= '0;
    end else if (cfg_wr) begin
      cfg_q[cfg_idx] <= apply_be(cfg_q[cfg_idx], periph_data_i, periph_be_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      job_count_q <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_count_q <= job_count_d;
      start_q     <= start_d;
    end
  end

  // Soft clear outranks a coincident done, so the count cannot survive a clear.
  always_comb begin
    state_d     = state_q;
    job_count_d = job_count_q;
    start_d     = 1'b0;
    if (clear_wr) begin
      state_d     = IDLE;
      job_count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_wr) begin
            state_d = RUNNING;
            start_d = 1'b1;
          end
        end
        RUNNING: begin
          if (done_i) begin
            state_d     = IDLE;
            job_count_d = job_count_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state_q == RUNNING);
    start_o = start_q;
  end

  for (genvar k = 0; k < NumRegs; k++) begin : g_cfg_out
    assign cfg_regs_o[32*k +: 32] = cfg_q[k];
  end

  assign periph_r_valid_o = r_valid_q;
  assign periph_r_data_o  = r_data_q;
  assign periph_r_id_o    = r_id_q;

endmodule

// File: tb/tb_snax_hwpe_periph_regfile.sv
// Directed self-checking bench for the periph register file: bus transfers,
// job control, count wrap, soft clear races and reset during a read.
module tb_snax_hwpe_periph_regfile;

  localparam int NumRegs = 16;
  localparam int IdWidth = 5;

  logic                  clk;
  logic                  rst;
  logic                  req;
  logic                  gnt;
  logic [31:0]           add;
  logic                  wen;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [IdWidth-1:0]    id;
  logic [31:0]           r_data;
  logic                  r_valid;
  logic [IdWidth-1:0]    r_id;
  logic [NumRegs*32-1:0] cfg_regs;
  logic                  start;
  logic                  done;
  logic                  busy;

  int checks;
  int failures;

  snax_hwpe_periph_regfile #(
    .NumRegs(NumRegs),
    .IdWidth(IdWidth),
    .RegBase(32'h40)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .periph_req_i    (req),
    .periph_gnt_o    (gnt),
    .periph_add_i    (add),
    .periph_wen_i    (wen),
    .periph_be_i     (be),
    .periph_data_i   (wdata),
    .periph_id_i     (id),
    .periph_r_data_o (r_data),
    .periph_r_valid_o(r_valid),
    .periph_r_id_o   (r_id),
    .cfg_regs_o      (cfg_regs),
    .start_o         (start),
    .done_i          (done),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; wen = 1'b0; add = a; wdata = d; be = b;
    #1 check_output({tag, "_gnt"}, 32'(gnt), 32'd1);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a,
                          input logic [IdWidth-1:0] rid, input logic [31:0] exp);
    @(negedge clk);
    req = 1'b1; wen = 1'b1; add = a; id = rid;
    #1 check_output({tag, "_gnt"}, 32'(gnt), 32'd1);
    @(negedge clk);
    #1;
    check_output({tag, "_rvalid"}, 32'(r_valid), 32'd1);
    check_output({tag, "_gnt_blocked"}, 32'(gnt), 32'd0);
    check_output({tag, "_data"}, r_data, exp);
    check_output({tag, "_id"}, 32'(r_id), 32'(rid));
    req = 1'b0;
    @(negedge clk);
    #1 check_output({tag, "_rvalid_drop"}, 32'(r_valid), 32'd0);
  endtask

  task automatic apply_stimulus_done;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    int acc;
    int rv;
    checks = 0; failures = 0;
    rst = 1'b1; req = 1'b0; add = '0; wen = 1'b0; be = '0; wdata = '0; id = '0; done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_gnt", 32'(gnt), 32'd0);
    check_output("rst_rvalid", 32'(r_valid), 32'd0);
    check_output("rst_rdata", r_data, 32'd0);
    check_output("rst_rid", 32'(r_id), 32'd0);
    check_output("rst_start", 32'(start), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_cfg_zero", 32'(cfg_regs == '0), 32'd1);
    rst = 1'b0;

    // Config register write/read with full and partial byte enables.
    bus_write("wr_cfg0", 32'h40, 32'hA5A5_1234, 4'hF);
    check_output("cfg0_out", cfg_regs[31:0], 32'hA5A5_1234);
    bus_read("rd_cfg0", 32'h40, 5'd3, 32'hA5A5_1234);
    bus_write("wr_cfg1_be", 32'h44, 32'hFFFF_FFFF, 4'h3);
    bus_read("rd_cfg1", 32'h44, 5'd4, 32'h0000_FFFF);
    bus_read("rd_unmapped", 32'h200, 5'd5, 32'h0);

    // Job start, ignored retrigger, completion, done while idle.
    bus_write("trig1", 32'h0, 32'h0, 4'hF);
    #1;
    check_output("start_pulse", 32'(start), 32'd1);
    check_output("busy_set", 32'(busy), 32'd1);
    @(negedge clk);
    #1 check_output("start_one_cycle", 32'(start), 32'd0);
    bus_read("status_run", 32'h4, 5'd6, 32'h0000_0001);
    bus_write("trig2", 32'h0, 32'h0, 4'hF);
    #1 check_output("retrigger_no_start", 32'(start), 32'd0);
    apply_stimulus_done();
    #1 check_output("busy_clear", 32'(busy), 32'd0);
    bus_read("status_done", 32'h4, 5'd7, 32'h0000_0100);
    apply_stimulus_done();
    bus_write("wr_status_ro", 32'h4, 32'hFFFF_FFFF, 4'hF);
    bus_read("status_idle_done", 32'h4, 5'd8, 32'h0000_0100);

    // Job counter wrap: 254 more jobs reach 255, one more wraps to 0.
    for (int j = 0; j < 254; j++) begin
      bus_write("trig_loop", 32'h0, 32'h0, 4'hF);
      apply_stimulus_done();
    end
    bus_read("status_255", 32'h4, 5'd9, 32'h0000_FF00);
    bus_write("trig_wrap", 32'h0, 32'h0, 4'hF);
    apply_stimulus_done();
    bus_read("status_wrap", 32'h4, 5'd10, 32'h0000_0000);

    // Held req across the response is accepted only once.
    acc = 0; rv = 0;
    @(negedge clk);
    req = 1'b1; wen = 1'b1; add = 32'h40; id = 5'd7;
    #1 begin acc += int'(req & gnt); rv += int'(r_valid); end
    @(negedge clk);
    #1 begin acc += int'(req & gnt); rv += int'(r_valid); end
    @(negedge clk);
    req = 1'b0;
    #1 begin acc += int'(req & gnt); rv += int'(r_valid); end
    @(negedge clk);
    #1 begin acc += int'(req & gnt); rv += int'(r_valid); end
    check_output("held_req_accepts", 32'(acc), 32'd1);
    check_output("held_req_rvalids", 32'(rv), 32'd1);
    check_output("held_req_data", r_data, 32'hA5A5_1234);

    // Soft clear coincident with done while running.
    bus_write("wr_cfg1_7", 32'h44, 32'h0000_0007, 4'hF);
    bus_write("trig_clr", 32'h0, 32'h0, 4'hF);
    #1 check_output("clr_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    req = 1'b1; wen = 1'b0; add = 32'h8; wdata = 32'h1; be = 4'hF; done = 1'b1;
    @(negedge clk);
    req = 1'b0; done = 1'b0;
    #1;
    check_output("clr_busy", 32'(busy), 32'd0);
    check_output("clr_cfg_zero", 32'(cfg_regs == '0), 32'd1);
    bus_read("clr_status", 32'h4, 5'd11, 32'h0);
    bus_read("clr_cfg1", 32'h44, 5'd12, 32'h0);

    // Reset arriving with an accepted read suppresses the response.
    bus_write("wr_cfg2", 32'h48, 32'h1234_5678, 4'hF);
    bus_read("rd_cfg2", 32'h48, 5'd13, 32'h1234_5678);
    @(negedge clk);
    req = 1'b1; wen = 1'b1; add = 32'h48; id = 5'd21;
    #1 check_output("rst_read_gnt", 32'(gnt), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    req = 1'b0;
    #1;
    check_output("rst_read_no_rvalid", 32'(r_valid), 32'd0);
    check_output("rst_read_rdata", r_data, 32'd0);
    check_output("rst_read_rid", 32'(r_id), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 check_output("rst_read_still_no_rvalid", 32'(r_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
